// File: rtl/data_reader_if.sv
// Bus bundle between data_reader, the read-only memory and the UART transmitter.
// master = data_reader side, slave = memory/transmitter/upstream side.
interface data_reader_if;
  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 8;

  logic              start;
  logic [DATA_W-1:0] Din;
  logic              Tx_tick;
  logic [ADDR_W-1:0] Addr;
  logic              Ren;
  logic [DATA_W-1:0] Dout;
  logic              Tx_start;
  logic              fin;

  modport master (
    input  start, Din, Tx_tick,
    output Addr, Ren, Dout, Tx_start, fin
  );

  modport slave (
    output start, Din, Tx_tick,
    input  Addr, Ren, Dout, Tx_start, fin
  );
endinterface

// File: rtl/data_reader.sv
// Streams memory bytes 0..LAST_ADDR to a UART transmitter, one byte per Tx_tick.
// Optional DATA_READER_CSUM_EN appends an 8-bit mod-256 checksum byte.
module data_reader #(
  parameter logic [17:0] LAST_ADDR = 18'd65535
) (
  input  logic          clk,
  input  logic          rst,
  data_reader_if.master bus
);

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 8;

`ifdef DATA_READER_CSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, WAIT, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, WAIT, DONE} state_t;
`endif

  state_t state;
  logic   start_d;
  logic   armed;
  logic   request;
`ifdef DATA_READER_CSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  // armed blocks a start level that was already high when reset released
  assign request = bus.start & ~start_d & armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.Addr     <= '0;
      bus.Dout     <= '0;
      bus.Ren      <= 1'b0;
      bus.Tx_start <= 1'b0;
      bus.fin      <= 1'b0;
      start_d      <= 1'b0;
      armed        <= 1'b0;
`ifdef DATA_READER_CSUM_EN
      sum          <= '0;
`endif
    end else begin
      start_d      <= bus.start;
      bus.Tx_start <= 1'b0;
      if (!bus.start) armed <= 1'b1;

      unique case (state)
        IDLE, DONE: begin
          if (request) begin
            bus.Addr <= '0;
            bus.Ren  <= 1'b1;
            bus.fin  <= 1'b0;
`ifdef DATA_READER_CSUM_EN
            sum      <= '0;
`endif
            state    <= FETCH;
          end
        end

        FETCH: begin
          bus.Ren <= 1'b0;
          state   <= LOAD;
        end

        // Tx_start is raised here so it is high for the whole SEND cycle
        LOAD: begin
          bus.Dout     <= bus.Din;
`ifdef DATA_READER_CSUM_EN
          sum          <= DATA_W'(sum + bus.Din);
`endif
          bus.Tx_start <= 1'b1;
          state        <= SEND;
        end

        SEND: state <= WAIT;

        WAIT: begin
          if (bus.Tx_tick) begin
            if (bus.Addr != LAST_ADDR) begin
              bus.Addr <= ADDR_W'(bus.Addr + ADDR_W'(1));
              bus.Ren  <= 1'b1;
              state    <= FETCH;
            end else begin
`ifdef DATA_READER_CSUM_EN
              bus.Dout     <= sum;
              bus.Tx_start <= 1'b1;
              state        <= CSUM;
`else
              bus.fin  <= 1'b1;
              bus.Addr <= '0;
              state    <= DONE;
`endif
            end
          end
        end

`ifdef DATA_READER_CSUM_EN
        // Checksum byte is in flight; Tx_start was pulsed on entry
        CSUM: begin
          if (bus.Tx_tick && !bus.Tx_start) begin
            bus.fin  <= 1'b1;
            bus.Addr <= '0;
            state    <= DONE;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_reader.sv
// Self-checking bench for data_reader: byte-stream model plus directed scenarios.
// Build with +define+DATA_READER_CSUM_EN to exercise the checksum variant.
module tb_data_reader;

  localparam logic [17:0] LAST     = 18'd3;
  localparam int unsigned TICK_DLY = 10;
`ifdef DATA_READER_CSUM_EN
  localparam int unsigned NBYTES   = 5;
`else
  localparam int unsigned NBYTES   = 4;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_reader_if bus ();

  data_reader #(.LAST_ADDR(LAST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [4];
  logic [7:0] din_q;
  logic       resp_tick;
  logic       stray_tick;
  int         resp_cnt;

  assign bus.Din     = din_q;
  assign bus.Tx_tick = resp_tick | stray_tick;

  // Synchronous memory: data appears the cycle after Addr with Ren
  always @(posedge clk) begin
    if (rst) din_q <= 8'd0;
    else if (bus.Ren) din_q <= mem[bus.Addr[1:0]];
  end

  // Transmitter: Tx_tick exactly TICK_DLY cycles after each Tx_start
  always @(posedge clk) begin
    resp_tick <= 1'b0;
    if (rst) resp_cnt <= 0;
    else if (bus.Tx_start) resp_cnt <= TICK_DLY;
    else if (resp_cnt != 0) begin
      resp_cnt <= resp_cnt - 1;
      if (resp_cnt == 1) resp_tick <= 1'b1;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the byte stream a transfer must produce, derived from memory contents
  logic [7:0] exp_q [$];
  logic [7:0] sent_q [$];
  int         n_popped;
  bit         busy;
  logic [7:0] held;
  bit         fin_prev;

  function automatic void build_model();
    logic [7:0] s;
    s = 8'd0;
    exp_q.delete();
    sent_q.delete();
    n_popped = 0;
    for (int i = 0; i <= int'(LAST); i++) begin
      exp_q.push_back(mem[i]);
      s = 8'(s + mem[i]);
    end
`ifdef DATA_READER_CSUM_EN
    exp_q.push_back(s);
`endif
  endfunction

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy     = 1'b0;
      fin_prev = 1'b0;
    end else begin
      chk("ren_txstart_exclusive", 32'(bus.Ren & bus.Tx_start), 32'd0);
      chk("addr_in_range", 32'(bus.Addr <= LAST), 32'd1);
      if (bus.Ren) chk("ren_addr", 32'(bus.Addr), 32'(n_popped));
      if (busy) chk("dout_hold", 32'(bus.Dout), 32'(held));
      if (bus.Tx_start) begin
        sent_q.push_back(bus.Dout);
        chk("tx_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("tx_byte", 32'(bus.Dout), 32'(exp_q.pop_front()));
        n_popped++;
        busy = 1'b1;
        held = bus.Dout;
      end
      if (resp_tick) busy = 1'b0;
      if (bus.fin && !fin_prev) chk("fin_all_sent", 32'(exp_q.size()), 32'd0);
      fin_prev = bus.fin;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fin();
    int i;
    for (i = 0; i < 500; i++) begin
      if (bus.fin) break;
      @(negedge clk);
    end
    if (i == 500) chk("fin_timeout", 32'(bus.fin), 32'd1);
  endtask

  // Raise start at a negedge; next edge is the request edge
  task automatic request();
    build_model();
    bus.start = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_mem(input logic [7:0] a, b, c, d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  initial begin
    int k;
    rst        = 1'b1;
    bus.start  = 1'b1;
    stray_tick = 1'b0;
    set_mem(8'd10, 8'd20, 8'd30, 8'd40);
    tick(3);
    chk("rst_addr", 32'(bus.Addr), 32'd0);
    chk("rst_ren", 32'(bus.Ren), 32'd0);
    chk("rst_dout", 32'(bus.Dout), 32'd0);
    chk("rst_txstart", 32'(bus.Tx_start), 32'd0);
    chk("rst_fin", 32'(bus.fin), 32'd0);
    rst = 1'b0;

    // start held high through reset, plus a stray tick in IDLE
    tick(5);
    stray_tick = 1'b1;
    tick(1);
    stray_tick = 1'b0;
    tick(14);
    chk("held_start_no_xfer", 32'(sent_q.size()), 32'd0);
    chk("idle_tick_addr", 32'(bus.Addr), 32'd0);
    chk("held_start_fin", 32'(bus.fin), 32'd0);
    bus.start = 1'b0;
    tick(2);

    // Transfer 1: directed latency, stray ticks in FETCH and SEND
    request();
    chk("a_c1_ren", 32'(bus.Ren), 32'd1);
    chk("a_c1_addr", 32'(bus.Addr), 32'd0);
    chk("a_c1_fin", 32'(bus.fin), 32'd0);
    stray_tick = 1'b1;
    tick(1);
    stray_tick = 1'b0;
    bus.start  = 1'b0;
    chk("a_c2_ren", 32'(bus.Ren), 32'd0);
    chk("a_c2_txstart", 32'(bus.Tx_start), 32'd0);
    tick(1);
    chk("a_c3_txstart", 32'(bus.Tx_start), 32'd1);
    chk("a_c3_dout", 32'(bus.Dout), 32'd10);
    stray_tick = 1'b1;
    tick(1);
    stray_tick = 1'b0;
    chk("a_c4_txstart", 32'(bus.Tx_start), 32'd0);
    chk("a_send_tick_addr", 32'(bus.Addr), 32'd0);
    wait_fin();
    chk("a_count", 32'(sent_q.size()), 32'(NBYTES));
    if (sent_q.size() >= 4) begin
      chk("a_b0", 32'(sent_q[0]), 32'd10);
      chk("a_b1", 32'(sent_q[1]), 32'd20);
      chk("a_b2", 32'(sent_q[2]), 32'd30);
      chk("a_b3", 32'(sent_q[3]), 32'd40);
    end
`ifdef DATA_READER_CSUM_EN
    if (sent_q.size() == 5) chk("a_csum", 32'(sent_q[4]), 32'h64);
`endif
    chk("a_fin", 32'(bus.fin), 32'd1);
    chk("a_addr_end", 32'(bus.Addr), 32'd0);
    chk("a_ren_end", 32'(bus.Ren), 32'd0);

    // Stray tick in DONE
    stray_tick = 1'b1;
    tick(1);
    stray_tick = 1'b0;
    tick(3);
    chk("done_tick_addr", 32'(bus.Addr), 32'd0);
    chk("done_tick_count", 32'(sent_q.size()), 32'(NBYTES));
    chk("done_fin_hold", 32'(bus.fin), 32'd1);

    // Transfer 2: start re-rises during WAIT, checksum wraps to zero
    set_mem(8'hFF, 8'hFF, 8'h02, 8'h00);
    request();
    chk("b_c1_fin", 32'(bus.fin), 32'd0);
    bus.start = 1'b0;
    tick(7);
    bus.start = 1'b1;
    tick(2);
    bus.start = 1'b0;
    wait_fin();
    chk("b_count", 32'(sent_q.size()), 32'(NBYTES));
    if (sent_q.size() >= 3) chk("b_b2", 32'(sent_q[2]), 32'h02);
`ifdef DATA_READER_CSUM_EN
    if (sent_q.size() == 5) chk("b_csum", 32'(sent_q[4]), 32'h00);
`endif

    // Transfer 3: start held high across DONE, then a fresh edge
    set_mem(8'd10, 8'd20, 8'd30, 8'd40);
    request();
    wait_fin();
    tick(30);
    chk("c_no_retransfer", 32'(sent_q.size()), 32'(NBYTES));
    chk("c_fin_hold", 32'(bus.fin), 32'd1);
    bus.start = 1'b0;
    tick(2);
    request();
    chk("c2_c1_fin", 32'(bus.fin), 32'd0);
    bus.start = 1'b0;
    wait_fin();
    chk("c2_count", 32'(sent_q.size()), 32'(NBYTES));
    if (sent_q.size() >= 4) chk("c2_b3", 32'(sent_q[3]), 32'd40);

    // Transfer 4: reset while waiting on byte at Addr=2
    tick(2);
    request();
    bus.start = 1'b0;
    for (k = 0; k < 200; k++) begin
      if (bus.Tx_start && bus.Addr == 18'd2) break;
      @(negedge clk);
    end
    if (k == 200) chk("d_reach_addr2", 32'(bus.Tx_start), 32'd1);
    tick(3);
    chk("d_wait_addr", 32'(bus.Addr), 32'd2);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    rst = 1'b0;
    chk("d_rst_addr", 32'(bus.Addr), 32'd0);
    chk("d_rst_ren", 32'(bus.Ren), 32'd0);
    chk("d_rst_dout", 32'(bus.Dout), 32'd0);
    chk("d_rst_txstart", 32'(bus.Tx_start), 32'd0);
    chk("d_rst_fin", 32'(bus.fin), 32'd0);
    tick(20);
    request();
    chk("d_restart_ren", 32'(bus.Ren), 32'd1);
    chk("d_restart_addr", 32'(bus.Addr), 32'd0);
    bus.start = 1'b0;
    wait_fin();
    chk("d_count", 32'(sent_q.size()), 32'(NBYTES));
    if (sent_q.size() >= 1) chk("d_b0", 32'(sent_q[0]), 32'd10);

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
